// File: rtl/fcu_pkg.sv
// Shared definitions for the fire control unit: state encodings and
// the default timing parameters.
package fcu_pkg;

    typedef enum logic [1:0] {
        SEARCH   = 2'b00,
        TRACK    = 2'b01,
        FIRE     = 2'b10,
        COOLDOWN = 2'b11
    } fcu_state_e;

    localparam int DEF_LOCK_CYCLES     = 4;
    localparam int DEF_ACK_TIMEOUT     = 8;
    localparam int DEF_COOLDOWN_CYCLES = 3;

endpackage

// File: rtl/fire_control_unit_lock_filter.sv
// Consecutive-contact filter: counts uninterrupted radar_contact cycles and
// flags the cycle whose edge completes the required run.
module lock_filter #(
    parameter int LOCK_CYCLES = fcu_pkg::DEF_LOCK_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic contact,
    output logic locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments and an async reset
    // in the sensitivity list, so reset acts without waiting for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || !contact) begin
            cnt <= '0;
        end else if (cnt != CNT_W'(LOCK_CYCLES)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Combinational look-ahead so the FSM moves on the very edge the count completes.
    assign locked = contact && !clear && (cnt >= CNT_W'(LOCK_CYCLES - 1));

endmodule

// File: rtl/fire_control_unit.sv
// Fire control FSM: acquires lock, issues a held fire request on a pilot
// trigger edge, waits for launch acknowledge with timeout, then cools down.
module fire_control_unit
    import fcu_pkg::*;
#(
    parameter int LOCK_CYCLES     = DEF_LOCK_CYCLES,
    parameter int ACK_TIMEOUT     = DEF_ACK_TIMEOUT,
    parameter int COOLDOWN_CYCLES = DEF_COOLDOWN_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       radar_contact,
    input  logic       pilot_trigger,
    input  logic       launch_missile,
    input  logic [3:0] remaining_missiles,
    output logic       target_locked,
    output logic       fire_command,
    output logic       fire_fault,
    output logic       winchester,
    output logic [1:0] FCU_state
);

    localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
    localparam int COOL_W = $clog2(COOLDOWN_CYCLES + 1);

    fcu_state_e        state, state_next;
    logic              trig_q, trig_edge, lock_hit, timeout, have_missiles;
    logic [WAIT_W-1:0] wait_cnt;
    logic [COOL_W-1:0] cool_cnt;

    assign trig_edge     = pilot_trigger & ~trig_q;
    assign have_missiles = (remaining_missiles != 4'd0);

    lock_filter #(.LOCK_CYCLES(LOCK_CYCLES)) u_lock_filter (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != SEARCH),
        .contact (radar_contact),
        .locked  (lock_hit)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        timeout    = 1'b0;
        case (state)
            SEARCH: begin
                if (lock_hit) state_next = TRACK;
            end
            TRACK: begin
                if (!radar_contact)                  state_next = SEARCH;
                else if (trig_edge && have_missiles) state_next = FIRE;
            end
            FIRE: begin
                // Acknowledge wins over contact loss and timeout in the same cycle.
                if (launch_missile)      state_next = COOLDOWN;
                else if (!radar_contact) state_next = SEARCH;
                else if (wait_cnt == WAIT_W'(ACK_TIMEOUT - 1)) begin
                    state_next = TRACK;
                    timeout    = 1'b1;
                end
            end
            COOLDOWN: begin
                if (!radar_contact)                                state_next = SEARCH;
                else if (cool_cnt == COOL_W'(COOLDOWN_CYCLES - 1)) state_next = TRACK;
            end
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= SEARCH;
            trig_q        <= 1'b0;
            wait_cnt      <= '0;
            cool_cnt      <= '0;
            target_locked <= 1'b0;
            fire_command  <= 1'b0;
            fire_fault    <= 1'b0;
            winchester    <= 1'b0;
        end else begin
            state         <= state_next;
            trig_q        <= pilot_trigger;
            wait_cnt      <= (state == FIRE && state_next == FIRE) ? wait_cnt + 1'b1 : '0;
            cool_cnt      <= (state == COOLDOWN && state_next == COOLDOWN) ? cool_cnt + 1'b1 : '0;
            target_locked <= (state_next != SEARCH);
            fire_command  <= (state_next == FIRE);
            fire_fault    <= timeout;
            winchester    <= !have_missiles;
        end
    end

    assign FCU_state = state;

endmodule

// File: tb/tb_fire_control_unit.sv
// Directed bench for fire_control_unit at default parameters; observed vector
// is {FCU_state, target_locked, fire_command, fire_fault, winchester}.
`timescale 1us / 1ns
module tb_fire_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       radar_contact = 1'b0;
    logic       pilot_trigger = 1'b0;
    logic       launch_missile = 1'b0;
    logic [3:0] remaining_missiles = 4'd4;
    logic       target_locked, fire_command, fire_fault, winchester;
    logic [1:0] FCU_state;
    logic [5:0] obs;

    int tests = 0;
    int failures = 0;

    localparam logic [5:0] S_SEARCH = 6'b000000;
    localparam logic [5:0] S_TRACK  = 6'b011000;
    localparam logic [5:0] S_FIRE   = 6'b101100;
    localparam logic [5:0] S_COOL   = 6'b111000;
    localparam logic [5:0] S_FAULT  = 6'b011010;
    localparam logic [5:0] S_WINCH  = 6'b011001;

    always #5 clk = ~clk;

    fire_control_unit dut (
        .clk                (clk),
        .rst                (rst),
        .radar_contact      (radar_contact),
        .pilot_trigger      (pilot_trigger),
        .launch_missile     (launch_missile),
        .remaining_missiles (remaining_missiles),
        .target_locked      (target_locked),
        .fire_command       (fire_command),
        .fire_fault         (fire_fault),
        .winchester         (winchester),
        .FCU_state          (FCU_state)
    );

    assign obs = {FCU_state, target_locked, fire_command, fire_fault, winchester};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        remaining_missiles = 4'd0;
        tick();
        tick();
        tests++;
        if (obs !== S_SEARCH) begin
            failures++;
            $display("FAIL reset_hold: obs=%b exp=%b", obs, S_SEARCH);
        end
        remaining_missiles = 4'd4;
        rst = 1'b0;
    endtask

    task automatic test_lock();
        radar_contact = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests++;
            if (obs !== ((i == 4) ? S_TRACK : S_SEARCH)) begin
                failures++;
                $display("FAIL lock_edge%0d: obs=%b exp=%b", i, obs, (i == 4) ? S_TRACK : S_SEARCH);
            end
        end
        radar_contact = 1'b0;
        tick();
        tests++;
        if (obs !== S_SEARCH) begin
            failures++;
            $display("FAIL track_contact_loss: obs=%b exp=%b", obs, S_SEARCH);
        end
    endtask

    task automatic test_gap();
        logic [7:0] pattern;
        pattern = 8'b1111_0111;  // applied LSB first: 1,1,1,0,1,1,1,1
        for (int i = 0; i < 8; i++) begin
            radar_contact = pattern[i];
            tick();
            tests++;
            if (obs !== ((i == 7) ? S_TRACK : S_SEARCH)) begin
                failures++;
                $display("FAIL gap_step%0d: obs=%b exp=%b", i, obs, (i == 7) ? S_TRACK : S_SEARCH);
            end
        end
        radar_contact = 1'b1;
    endtask

    task automatic test_fire_launch();
        logic [5:0] exp_seq [7];
        exp_seq = '{S_FIRE, S_FIRE, S_FIRE, S_COOL, S_COOL, S_COOL, S_TRACK};
        pilot_trigger = 1'b1;
        for (int i = 0; i < 7; i++) begin
            launch_missile = (i == 3);
            if (i == 4) pilot_trigger = 1'b0;
            if (i == 5) pilot_trigger = 1'b1;  // edge inside COOLDOWN must be dropped
            tick();
            tests++;
            if (obs !== exp_seq[i]) begin
                failures++;
                $display("FAIL launch_e%0d: obs=%b exp=%b", i, obs, exp_seq[i]);
            end
        end
        launch_missile = 1'b0;
        tick();
        tests++;
        if (obs !== S_TRACK) begin
            failures++;
            $display("FAIL cooldown_edge_not_queued: obs=%b exp=%b", obs, S_TRACK);
        end
        pilot_trigger = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        pilot_trigger = 1'b1;
        for (int i = 0; i <= 9; i++) begin
            logic [5:0] exp_v;
            exp_v = (i < 8) ? S_FIRE : ((i == 8) ? S_FAULT : S_TRACK);
            tick();
            tests++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL timeout_e%0d: obs=%b exp=%b", i, obs, exp_v);
            end
        end
        pilot_trigger = 1'b0;
        launch_missile = 1'b1;
        tick();
        tests++;
        if (obs !== S_TRACK) begin
            failures++;
            $display("FAIL launch_outside_fire: obs=%b exp=%b", obs, S_TRACK);
        end
        launch_missile = 1'b0;
    endtask

    task automatic test_winchester();
        remaining_missiles = 4'd0;
        #1;
        tests++;
        if (winchester !== 1'b0) begin
            failures++;
            $display("FAIL winchester_latency: winchester=%b exp=0", winchester);
        end
        tick();
        pilot_trigger = 1'b1;
        tick();
        tests++;
        if (obs !== S_WINCH) begin
            failures++;
            $display("FAIL winchester_no_fire: obs=%b exp=%b", obs, S_WINCH);
        end
        pilot_trigger = 1'b0;
        remaining_missiles = 4'd4;
        tick();
        tests++;
        if (obs !== S_TRACK) begin
            failures++;
            $display("FAIL winchester_clear: obs=%b exp=%b", obs, S_TRACK);
        end
    endtask

    task automatic test_launch_with_loss();
        pilot_trigger = 1'b1;
        tick();
        tests++;
        if (obs !== S_FIRE) begin
            failures++;
            $display("FAIL loss_enter_fire: obs=%b exp=%b", obs, S_FIRE);
        end
        pilot_trigger = 1'b0;
        radar_contact = 1'b0;
        launch_missile = 1'b1;
        tick();
        tests++;
        if (obs !== S_COOL) begin
            failures++;
            $display("FAIL loss_launch_priority: obs=%b exp=%b", obs, S_COOL);
        end
        launch_missile = 1'b0;
        tick();
        tests++;
        if (obs !== S_SEARCH) begin
            failures++;
            $display("FAIL loss_cooldown_to_search: obs=%b exp=%b", obs, S_SEARCH);
        end
    endtask

    task automatic test_reset_mid_fire();
        radar_contact = 1'b1;
        repeat (4) tick();
        pilot_trigger = 1'b1;
        tick();
        tests++;
        if (obs !== S_FIRE) begin
            failures++;
            $display("FAIL rst_pre_fire: obs=%b exp=%b", obs, S_FIRE);
        end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (obs !== S_SEARCH) begin
            failures++;
            $display("FAIL rst_async_drop: obs=%b exp=%b", obs, S_SEARCH);
        end
        tick();
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            tests++;
            if (obs !== ((i >= 4) ? S_TRACK : S_SEARCH)) begin
                failures++;
                $display("FAIL reacquire_edge%0d: obs=%b exp=%b", i, obs, (i >= 4) ? S_TRACK : S_SEARCH);
            end
        end
        pilot_trigger = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_gap();
        test_fire_launch();
        test_timeout();
        test_winchester();
        test_launch_with_loss();
        test_reset_mid_fire();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
